// File: rtl/round_scheduler.sv
// round_scheduler: Moore FSM that launches theta/rho/pi/chi/addRC once per round
// and sequences NUM_ROUNDS rounds per start request.
module round_scheduler #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       theta_done,
  input  logic       rho_done,
  input  logic       pi_done,
  input  logic       chi_done,
  input  logic       addrc_done,
  output logic       theta_en,
  output logic       rho_en,
  output logic       pi_en,
  output logic       chi_en,
  output logic       addrc_en,
  output logic [4:0] round_idx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [3:0] {
    IDLE, TH_GO, TH_WAIT, RHO_GO, RHO_WAIT, PI_GO, PI_WAIT,
    CHI_GO, CHI_WAIT, RC_GO, RC_WAIT, RND_INC, FINISH
  } state_t;
  state_t state, state_nx;
  logic last;
  assign last = round_idx == 5'(NUM_ROUNDS - 1);
  // Clearing on the transition into IDLE keeps round_idx at 0 for every IDLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      round_idx <= '0;
    end else begin
      state     <= state_nx;
      round_idx <= state_nx == IDLE ? '0 : state == RND_INC ? round_idx + 5'd1 : round_idx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? TH_GO : IDLE;
      TH_GO:    state_nx = TH_WAIT;
      TH_WAIT:  state_nx = theta_done ? RHO_GO : TH_WAIT;
      RHO_GO:   state_nx = RHO_WAIT;
      RHO_WAIT: state_nx = rho_done ? PI_GO : RHO_WAIT;
      PI_GO:    state_nx = PI_WAIT;
      PI_WAIT:  state_nx = pi_done ? CHI_GO : PI_WAIT;
      CHI_GO:   state_nx = CHI_WAIT;
      CHI_WAIT: state_nx = chi_done ? RC_GO : CHI_WAIT;
      RC_GO:    state_nx = RC_WAIT;
      RC_WAIT:  state_nx = !addrc_done ? RC_WAIT : last ? FINISH : RND_INC;
      RND_INC:  state_nx = TH_GO;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  assign theta_en = state == TH_GO;
  assign rho_en   = state == RHO_GO;
  assign pi_en    = state == PI_GO;
  assign chi_en   = state == CHI_GO;
  assign addrc_en = state == RC_GO;
  assign busy     = state != IDLE;
  assign done     = state == FINISH;
endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: table-driven single-round checks plus model-checked random 24-round runs.
module tb_round_scheduler;
  localparam int NR = 24;
  logic clk = 0, rst = 1, start = 0, start1 = 0;
  logic [4:0] dn = '0, dn1 = '0, en, en1, ri, ri1;
  logic busy, done, busy1, done1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  round_scheduler #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .theta_done(dn[0]), .rho_done(dn[1]), .pi_done(dn[2]), .chi_done(dn[3]), .addrc_done(dn[4]),
    .theta_en(en[0]), .rho_en(en[1]), .pi_en(en[2]), .chi_en(en[3]), .addrc_en(en[4]),
    .round_idx(ri), .busy(busy), .done(done)
  );

  round_scheduler #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .theta_done(dn1[0]), .rho_done(dn1[1]), .pi_done(dn1[2]), .chi_done(dn1[3]), .addrc_done(dn1[4]),
    .theta_en(en1[0]), .rho_en(en1[1]), .pi_en(en1[2]), .chi_en(en1[3]), .addrc_en(en1[4]),
    .round_idx(ri1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic       st;
    logic [4:0] d;
    logic [4:0] en;
    logic       bz;
    logic       dn;
  } vec_t;
  vec_t tbl[15];

  task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: en/busy/done/round got %b/%b/%b/%0d want %b/%b/%b/%0d",
               nm, act[11:7], act[6], act[5], act[4:0], exp[11:7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic cmpi(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: each launch is followed by its done after a chosen delay; the next launch
  // lands one cycle after the accepted done (two after addRC, for the round increment).
  task automatic run(input string nm, input int max_d, input bit noise,
                     input int stall_rnd, input int start_rnd, input int abort_rnd);
    int cyc, unit, rnd, nx_unit, nx_rnd, next_en, go_cyc, resp_cyc, fin_cyc, obs_done, d;
    int cnt[5];
    bit fin, ab;
    logic [4:0] ee;
    cyc = 0; unit = 0; rnd = 0; nx_unit = 0; nx_rnd = 0; next_en = 1; go_cyc = 0;
    resp_cyc = -1; fin_cyc = -1; obs_done = -1; fin = 0; ab = 0;
    for (int u = 0; u < 5; u++) cnt[u] = 0;
    @(negedge clk);
    start = 1;
    dn = '0;
    while (!fin && !ab && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == next_en) begin
        unit = nx_unit;
        rnd = nx_rnd;
        go_cyc = cyc;
      end
      ee = cyc == next_en ? 5'(1 << unit) : 5'd0;
      cmp(nm, {en, busy, done, ri}, {ee, 1'b1, cyc == fin_cyc, 5'(rnd)});
      for (int u = 0; u < 5; u++) cnt[u] += int'(en[u]);
      if (done) obs_done = cyc;
      fin = cyc == fin_cyc;
      if (cyc == go_cyc + 1 && unit == 1 && rnd == abort_rnd) begin
        start = 0;
        dn = '0;
        #2 rst = 0;
        #1 cmp({nm, "_async_rst"}, {en, busy, done, ri}, 12'd0);
        @(negedge clk);
        cmp({nm, "_rst_hold"}, {en, busy, done, ri}, 12'd0);
        rst = 1;
        ab = 1;
      end else begin
        if (cyc == next_en) begin
          d = (unit == 3 && rnd == stall_rnd) ? 7 : int'($urandom_range(max_d, 0));
          resp_cyc = cyc + 1 + d;
          if (unit < 4) begin
            next_en = cyc + 2 + d;
            nx_unit = unit + 1;
            nx_rnd = rnd;
          end else if (rnd == NR - 1) fin_cyc = cyc + 2 + d;
          else begin
            next_en = cyc + 3 + d;
            nx_unit = 0;
            nx_rnd = rnd + 1;
          end
        end
        dn = noise ? 5'($urandom) : 5'd0;
        if (cyc != go_cyc) dn[unit] = cyc == resp_cyc;
        start = !fin && (rnd == start_rnd || (noise && $urandom_range(3, 0) == 0));
      end
    end
    cmpi({nm, "_terminated"}, int'(fin || ab), 1);
    start = 0;
    dn = '0;
    @(negedge clk);
    cmp({nm, "_idle"}, {en, busy, done, ri}, 12'd0);
    if (!ab) for (int u = 0; u < 5; u++) cmpi({nm, "_en_count"}, cnt[u], NR);
    if (!ab && max_d == 0) cmpi({nm, "_run_len"}, obs_done, 11 * NR);
  endtask

  initial begin
    tbl[0]  = {1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[1]  = {1'b0, 5'b00011, 5'b00001, 1'b1, 1'b0};
    tbl[2]  = {1'b0, 5'b00010, 5'b00000, 1'b1, 1'b0};
    tbl[3]  = {1'b0, 5'b00001, 5'b00000, 1'b1, 1'b0};
    tbl[4]  = {1'b0, 5'b00000, 5'b00010, 1'b1, 1'b0};
    tbl[5]  = {1'b0, 5'b00010, 5'b00000, 1'b1, 1'b0};
    tbl[6]  = {1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[7]  = {1'b0, 5'b00100, 5'b00000, 1'b1, 1'b0};
    tbl[8]  = {1'b0, 5'b00000, 5'b01000, 1'b1, 1'b0};
    tbl[9]  = {1'b0, 5'b01000, 5'b00000, 1'b1, 1'b0};
    tbl[10] = {1'b0, 5'b00000, 5'b10000, 1'b1, 1'b0};
    tbl[11] = {1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0};
    tbl[12] = {1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1};
    tbl[13] = {1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[14] = {1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    #1 rst = 0;
    #1 cmp("reset_async", {en, busy, done, ri}, 12'd0);
    cmp("reset_async_r1", {en1, busy1, done1, ri1}, 12'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    cmp("post_release", {en, busy, done, ri}, 12'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cmp($sformatf("single_round_row%0d", i), {en1, busy1, done1, ri1},
          {tbl[i].en, tbl[i].bz, tbl[i].dn, 5'd0});
      start1 = tbl[i].st;
      dn1 = tbl[i].d;
    end
    run("basic", 0, 0, -1, -1, -1);
    run("stall_busy_start", 4, 1, 5, 3, -1);
    run("abort", 3, 1, -1, -1, 10);
    run("after_abort", 2, 1, -1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/round_scheduler.md
ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 24, giving the number of permutation rounds per run (legal range 1..31).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port start, input, 1 bit: request one full run; sampled only in IDLE.
REQ-005 SHALL have ports theta_done, rho_done, pi_done, chi_done, addrc_done, input, 1 bit each: completion pulses from the step-mapping units.
REQ-006 SHALL have ports theta_en, rho_en, pi_en, chi_en, addrc_en, output, 1 bit each: one-cycle launch pulses to the step-mapping units.
REQ-007 SHALL have port round_idx, output, 5 bits: current round number, used by the addRC unit to select the round constant.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the final round completes.

Function
REQ-010 SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state and round_idx only.
REQ-011 SHALL implement states IDLE, TH_GO, TH_WAIT, RHO_GO, RHO_WAIT, PI_GO, PI_WAIT, CHI_GO, CHI_WAIT, RC_GO, RC_WAIT, RND_INC, FINISH.
REQ-012 SHALL transition IDLE->TH_GO when start=1, else remain in IDLE.
REQ-013 SHALL transition each X_GO->X_WAIT unconditionally after one cycle, with the matching X_en=1 only in X_GO.
REQ-014 SHALL remain in X_WAIT until the matching X_done=1, then advance TH->RHO->PI->CHI->RC.
REQ-015 SHALL, in RC_WAIT with addrc_done=1, go to FINISH if round_idx==NUM_ROUNDS-1, else to RND_INC.
REQ-016 SHALL increment round_idx by 1 in RND_INC and go to TH_GO the next cycle.
REQ-017 SHALL assert done=1 only in FINISH, then return to IDLE the next cycle.
REQ-018 SHALL clear round_idx to 0 whenever the state is IDLE; round_idx SHALL hold its final value (NUM_ROUNDS-1) during FINISH.
REQ-019 SHALL ignore any *_done input that does not match the current X_WAIT state, including done pulses that arrive during an X_GO cycle.
REQ-020 SHALL ignore start while busy=1; a new run requires start in IDLE.
REQ-021 SHALL yield a minimum run length of 11*NUM_ROUNDS cycles from TH_GO entry to FINISH exit, with every done responded to in the same cycle.
REQ-022 SHALL assert at most one *_en output in any cycle.

Reset
REQ-023 SHALL, while rst=0, force the state to IDLE and round_idx to 0 immediately, regardless of clk.
REQ-024 SHALL drive all *_en=0, busy=0 and done=0 while reset is asserted and in the first cycle after release.
REQ-025 SHALL abort any run in progress on reset, with no done pulse generated.

Verification
REQ-026 SHALL check basic run: NUM_ROUNDS=24, start pulse, each unit returns done 1 cycle after en -> exactly 24 each of theta_en..addrc_en, round_idx 0..23 in order, done pulse at cycle 264 after TH_GO entry, busy low afterwards.
REQ-027 SHALL check stall: chi_done delayed 7 cycles in round 5 -> FSM holds in CHI_WAIT, no en pulses, round_idx=5 throughout the stall.
REQ-028 SHALL check spurious done: rho_done=1 during TH_WAIT and theta_done=1 during TH_GO -> both ignored, state remains TH_WAIT until a real theta_done arrives.
REQ-029 SHALL check start while busy: start=1 in round 3 -> no restart; round_idx continues 3->4.
REQ-030 SHALL check reset mid-run: rst=0 asynchronously in RHO_WAIT of round 10 -> outputs 0 and round_idx=0 immediately; after release and start, run begins at round_idx=0.
REQ-031 SHALL check single-round run: NUM_ROUNDS=1 -> one pulse of each en, no RND_INC state entered, done after addrc_done, round_idx=0 throughout.
